// File: rtl/fmm_reduce_kernel_pivot_row_eliminate.sv
// GF(2) row elimination against a pivot row in the shared M_e buffer.
// Every other row flagged in the pivot column gets the pivot row XORed in.
module fmm_reduce_kernel_pivot_row_eliminate #(
  parameter int ROW_STRIDE = 320,
  parameter int ADDR_W     = 17
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  output logic                     ap_done,
  output logic                     ap_idle,
  output logic                     ap_ready,
  input  logic signed [31:0]       pivot_row,
  input  logic        [ADDR_W-1:0] pivot_col,
  input  logic signed [31:0]       rowt,
  input  logic signed [31:0]       colt,
  output logic        [ADDR_W-1:0] M_e_address0,
  output logic                     M_e_ce0,
  output logic                     M_e_we0,
  output logic        [31:0]       M_e_d0,
  input  logic        [31:0]       M_e_q0,
  output logic        [31:0]       elim_count,
  output logic                     elim_count_ap_vld
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_SEL,
    S_CHK_RD,
    S_CHK_EV,
    S_PV_RD,
    S_TG_RD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ROW_STRIDE);

  state_t state, state_n;

  logic signed [31:0] piv_q;
  logic signed [31:0] rowt_q;
  logic signed [31:0] colt_q;
  logic signed [31:0] r_q;
  logic signed [31:0] c_q;
  logic [ADDR_W-1:0]  pcol_q;
  logic [ADDR_W-1:0]  pbase_q;
  logic [ADDR_W-1:0]  tbase_q;
  logic [31:0]        pv_q;
  logic [31:0]        cnt_q;
  logic               degen_q;

  logic               degen_in;
  logic               row_adv;
  logic               hit;
  logic               last_col;
  logic signed [31:0] c_inc;

  assign degen_in = (pivot_row < 0) || (rowt <= 0) ||
                    (colt <= 0) || (pivot_row >= rowt);
  assign hit      = (M_e_q0 == 32'd1);
  assign c_inc    = c_q + 32'sd1;
  assign last_col = (c_inc == colt_q);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n           = state;
    row_adv           = 1'b0;
    M_e_address0      = '0;
    M_e_ce0           = 1'b0;
    M_e_we0           = 1'b0;
    M_e_d0            = '0;
    ap_done           = 1'b0;
    ap_ready          = 1'b0;
    elim_count_ap_vld = 1'b0;
    ap_idle           = 1'b0;
    unique case (state)
      S_IDLE: begin
        ap_idle = !ap_start;
        if (ap_start) state_n = S_ROW_SEL;
      end
      S_ROW_SEL: begin
        if (degen_q || (r_q == rowt_q)) begin
          state_n = S_DONE;
        end else if (r_q == piv_q) begin
          row_adv = 1'b1;
        end else begin
          state_n = S_CHK_RD;
        end
      end
      S_CHK_RD: begin
        M_e_ce0      = 1'b1;
        M_e_address0 = tbase_q + pcol_q;
        state_n      = S_CHK_EV;
      end
      S_CHK_EV: begin
        if (hit) begin
          state_n = S_PV_RD;
        end else begin
          row_adv = 1'b1;
          state_n = S_ROW_SEL;
        end
      end
      S_PV_RD: begin
        M_e_ce0      = 1'b1;
        M_e_address0 = pbase_q + c_q[ADDR_W-1:0];
        state_n      = S_TG_RD;
      end
      S_TG_RD: begin
        M_e_ce0      = 1'b1;
        M_e_address0 = tbase_q + c_q[ADDR_W-1:0];
        state_n      = S_WR;
      end
      S_WR: begin
        M_e_ce0      = 1'b1;
        M_e_we0      = 1'b1;
        M_e_address0 = tbase_q + c_q[ADDR_W-1:0];
        M_e_d0       = pv_q ^ M_e_q0;
        if (last_col) begin
          row_adv = 1'b1;
          state_n = S_ROW_SEL;
        end else begin
          state_n = S_PV_RD;
        end
      end
      S_DONE: begin
        ap_done           = 1'b1;
        ap_ready          = 1'b1;
        elim_count_ap_vld = 1'b1;
        state_n           = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Target base walks by stride so no per-row multiply is needed
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      piv_q   <= '0;
      rowt_q  <= '0;
      colt_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      pcol_q  <= '0;
      pbase_q <= '0;
      tbase_q <= '0;
      pv_q    <= '0;
      cnt_q   <= '0;
      degen_q <= 1'b0;
    end else begin
      if (state == S_IDLE && ap_start) begin
        piv_q   <= pivot_row;
        rowt_q  <= rowt;
        colt_q  <= colt;
        pcol_q  <= pivot_col;
        pbase_q <= ADDR_W'(pivot_row * ROW_STRIDE);
        tbase_q <= '0;
        r_q     <= '0;
        cnt_q   <= '0;
        degen_q <= degen_in;
      end
      if (state == S_CHK_EV && hit) begin
        c_q   <= '0;
        cnt_q <= cnt_q + 32'd1;
      end
      if (state == S_TG_RD) pv_q <= M_e_q0;
      if (state == S_WR) c_q <= c_inc;
      if (row_adv) begin
        r_q     <= r_q + 32'sd1;
        tbase_q <= tbase_q + STRIDE;
      end
    end
  end

  assign elim_count = cnt_q;

endmodule

// File: tb/tb_fmm_reduce_kernel_pivot_row_eliminate.sv
// Randomized scoreboard bench for the pivot-row GF(2) eliminator.
// Reference model works directly on a flat word array.
module tb_fmm_reduce_kernel_pivot_row_eliminate;

  localparam int STRIDE = 320;
  localparam int AW     = 17;
  localparam int MSZ    = 1 << AW;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          ap_start;
  logic          ap_done, ap_idle, ap_ready;
  logic [31:0]   pivot_row;
  logic [AW-1:0] pivot_col;
  logic [31:0]   rowt, colt;
  logic [AW-1:0] M_e_address0;
  logic          M_e_ce0, M_e_we0;
  logic [31:0]   M_e_d0;
  logic [31:0]   M_e_q0 = '0;
  logic [31:0]   elim_count;
  logic          elim_count_ap_vld;

  fmm_reduce_kernel_pivot_row_eliminate #(
    .ROW_STRIDE(STRIDE),
    .ADDR_W(AW)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .ap_ready(ap_ready),
    .pivot_row(pivot_row),
    .pivot_col(pivot_col),
    .rowt(rowt),
    .colt(colt),
    .M_e_address0(M_e_address0),
    .M_e_ce0(M_e_ce0),
    .M_e_we0(M_e_we0),
    .M_e_d0(M_e_d0),
    .M_e_q0(M_e_q0),
    .elim_count(elim_count),
    .elim_count_ap_vld(elim_count_ap_vld)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int cnt;
    int lat;
    int rd;
    int wr;
    int pvrd;
    int pbase;
    int colt;
    int acc;
  } exp_t;

  exp_t exp_q[$];

  bit [31:0] mem     [MSZ];
  bit [31:0] ref_mem [MSZ];

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int done_cnt = 0;
  int m_rd = 0, m_wr = 0, m_pvrd = 0, m_wrpv = 0;

  always @(posedge ap_clk) begin
    cyc <= cyc + 1;
    if (M_e_ce0) begin
      if (M_e_we0) mem[M_e_address0] <= M_e_d0;
      else M_e_q0 <= mem[M_e_address0];
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int addr_of(input int r, input int c);
    return (r * STRIDE + c) % MSZ;
  endfunction

  // Straight-line elimination over the array, accumulating cost
  task automatic model(input int pr, input int pc, input int rt,
                       input int ct, output exp_t e);
    int sum;
    e = '{default: 0};
    e.colt = ct;
    sum = 0;
    if (!(pr < 0 || rt <= 0 || ct <= 0 || pr >= rt)) begin
      e.pbase = addr_of(pr, 0);
      for (int r = 0; r < rt; r++) begin
        if (r == pr) begin
          sum += 1;
        end else begin
          sum += 3;
          e.rd += 1;
          if (ref_mem[addr_of(r, pc)] == 32'd1) begin
            e.cnt += 1;
            sum += 3 * ct;
            for (int c = 0; c < ct; c++) begin
              ref_mem[addr_of(r, c)] ^= ref_mem[addr_of(pr, c)];
              e.rd += 2;
              e.wr += 1;
              e.pvrd += 1;
            end
          end
        end
      end
    end
    e.lat = 2 + sum;
  endtask

  task automatic set_both(input int a, input bit [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  function automatic bit [31:0] pick();
    int k;
    k = $urandom_range(0, 9);
    if (k < 4) return 32'd0;
    if (k < 8) return 32'd1;
    if (k == 8) return 32'd2;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic fill(input int rt);
    for (int r = 0; r < rt; r++)
      for (int c = 0; c < 8; c++)
        set_both(addr_of(r, c), pick());
  endtask

  always @(negedge ap_clk) begin
    exp_t e;
    int bad;
    bit in_pv;
    if (!ap_rst_n) begin
      m_rd = 0;
      m_wr = 0;
      m_pvrd = 0;
      m_wrpv = 0;
    end else begin
      if (M_e_ce0 && exp_q.size() > 0) begin
        e = exp_q[0];
        in_pv = int'(M_e_address0) >= e.pbase &&
                int'(M_e_address0) < e.pbase + e.colt;
        if (M_e_we0) begin
          m_wr++;
          if (in_pv) m_wrpv++;
        end else begin
          m_rd++;
          if (in_pv) m_pvrd++;
        end
      end
      if (ap_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("elim_count", elim_count, e.cnt);
          chk("done_latency", cyc - e.acc, e.lat);
          chk("ap_ready", ap_ready, 1);
          chk("ap_vld", elim_count_ap_vld, 1);
          chk("ram_reads", m_rd, e.rd);
          chk("ram_writes", m_wr, e.wr);
          chk("pivot_reads", m_pvrd, e.pvrd);
          chk("pivot_writes", m_wrpv, 0);
          bad = 0;
          for (int a = 0; a < MSZ; a++)
            if (mem[a] != ref_mem[a]) bad++;
          chk("mem_words_wrong", bad, 0);
        end
        m_rd = 0;
        m_wr = 0;
        m_pvrd = 0;
        m_wrpv = 0;
        done_cnt++;
      end
    end
  end

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  endtask

  task automatic launch(input int pr, input int pc, input int rt, input int ct);
    exp_t e;
    model(pr, pc, rt, ct, e);
    @(negedge ap_clk);
    pivot_row = pr;
    pivot_col = AW'(pc);
    rowt = rt;
    colt = ct;
    ap_start = 1'b1;
    e.acc = cyc;
    exp_q.push_back(e);
    @(negedge ap_clk);
    ap_start = 1'b0;
  endtask

  task automatic run(input int pr, input int pc, input int rt, input int ct);
    int base;
    bit seen;
    base = done_cnt;
    launch(pr, pc, rt, ct);
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge ap_clk);
      #1;
      if (done_cnt != base) seen = 1;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      finish_now();
    end
  endtask

  initial begin
    int pr, rt, ct;
    bit seen;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    pivot_row = '0;
    pivot_col = '0;
    rowt = '0;
    colt = '0;
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_ce", M_e_ce0, 0);
    chk("rst_count", elim_count, 0);
    chk("rst_vld", elim_count_ap_vld, 0);
    ap_rst_n = 1'b1;

    run(-1, 0, 4, 4);

    for (int c = 0; c < 4; c++) begin
      set_both(addr_of(0, c), (c >= 2) ? 32'd1 : 32'd0);
      set_both(addr_of(1, c), (c <= 2) ? 32'd1 : 32'd0);
      set_both(addr_of(2, c), c[0] ? 32'd1 : 32'd0);
    end
    run(1, 2, 3, 4);
    chk("row0_c0", mem[0], 1);
    chk("row0_c1", mem[1], 1);
    chk("row0_c2", mem[2], 0);
    chk("row0_c3", mem[3], 1);

    set_both(addr_of(0, 2), 32'd1);
    set_both(addr_of(2, 2), 32'd2);
    run(1, 2, 3, 4);
    chk("row2_flag2_kept", mem[addr_of(2, 2)], 2);

    fill(4);
    for (int r = 1; r < 4; r++) set_both(addr_of(r, 0), 32'd1);
    run(0, 0, 4, 2);

    fill(402);
    set_both(addr_of(401, 1), 32'd1);
    run(400, 1, 402, 3);

    fill(6);
    run(2, 1, 2, 3);
    run(0, 1, 0, 3);
    run(0, 1, 3, 0);

    fill(4);
    for (int r = 0; r < 4; r++) set_both(addr_of(r, 0), 32'd1);
    launch(0, 0, 4, 3);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge ap_clk);
      if (M_e_we0) seen = 1;
    end
    chk("saw_wr_cycle", seen, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_ce", M_e_ce0, 0);
    chk("midrst_we", M_e_we0, 0);
    chk("midrst_done", ap_done, 0);
    chk("midrst_count", elim_count, 0);
    chk("midrst_idle", ap_idle, 1);
    exp_q.delete();
    repeat (2) @(negedge ap_clk);
    fill(5);
    ap_rst_n = 1'b1;
    run(3, 0, 5, 4);

    for (int k = 0; k < 14; k++) begin
      rt = $urandom_range(1, 6);
      ct = $urandom_range(1, 6);
      pr = $urandom_range(0, rt + 1) - 1;
      fill(rt);
      run(pr, $urandom_range(0, 7), rt, ct);
    end

    chk("queue_drained", exp_q.size(), 0);
    finish_now();
  end

endmodule

// File: doc/fmm_reduce_kernel_pivot_row_eliminate.md
Name: fmm_reduce_kernel_pivot_row_eliminate

Overview:
- Downstream stage of the pivot-row search loop in greedy_potential_reduce. That loop returns the first row whose element in the current column equals 1, or -1 if no row qualifies.
- This block takes that pivot row and column and performs GF(2) elimination on the shared M_e buffer: for every other row r with M_e[r][col]==1, it replaces row r with row r XOR pivot row across all active columns.
- M_e is a row-major array of 32-bit words holding 0/1, with a fixed row stride. The block reports how many rows it eliminated.

Parameters:
- ROW_STRIDE, 320, words between consecutive rows of M_e
- ADDR_W, 17, M_e address width; all addresses are truncated to this width

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  start request; operands sampled on accept
- ap_done  out  1  one-cycle completion pulse
- ap_idle  out  1  high in IDLE while ap_start is low
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- pivot_row  in  32  signed pivot row from the search stage; negative means no pivot
- pivot_col  in  ADDR_W  column offset of the pivot column
- rowt  in  32  signed active row count
- colt  in  32  signed active column count
- M_e_address0  out  ADDR_W  single-port RAM address
- M_e_ce0  out  1  RAM enable
- M_e_we0  out  1  RAM write enable
- M_e_d0  out  32  RAM write data
- M_e_q0  in  32  RAM read data, valid the cycle after a read
- elim_count  out  32  rows eliminated by the last run; holds until the next accept
- elim_count_ap_vld  out  1  high with ap_done

Behaviour:
- Clock and reset: one clock, ap_clk; reset is asynchronous and active-low, ap_rst_n.
- Reset values: state=IDLE; all outputs 0 except ap_idle, which follows the IDLE rule; elim_count=0.
- Reset mid-run returns to IDLE immediately. A partially updated M_e row is left as is; there is no recovery.
- Address rules:
  - Row base = row*ROW_STRIDE.
  - Element address = (row base + column) mod 2^ADDR_W.
  - The pivot base is computed once on accept.
  - The target base increments by ROW_STRIDE per row; no per-cycle multiplier.
- Accept: ap_start high in IDLE latches pivot_row, pivot_col, rowt and colt, clears the count, and sets r=0.
- Degenerate run: if pivot_row<0, rowt<=0, colt<=0, or pivot_row>=rowt, go to DONE with count 0 and no RAM access.
- State machine:
  - IDLE: wait for accept.
  - ROW_SEL: if r==rowt go to DONE. If r==pivot_row, advance r and stay in ROW_SEL (1 cycle). Otherwise go to CHK_RD.
  - CHK_RD: read M_e[r][pivot_col], then go to CHK_EV.
  - CHK_EV: if M_e_q0==32'd1, set c=0, increment the count and go to PV_RD. Otherwise advance r and go to ROW_SEL.
  - PV_RD: read M_e[pivot][c].
  - TG_RD: latch M_e_q0 as pv, then read M_e[r][c].
  - WR: write pv XOR M_e_q0 to M_e[r][c] with we=1. Then c++; if c==colt, advance r and go to ROW_SEL, else go to PV_RD.
  - DONE: assert ap_done, ap_ready and elim_count_ap_vld for one cycle, then go to IDLE.
- Cost: a flagged row costs 3 + 3*colt cycles; an unflagged row costs 3; the pivot row costs 1.
- Flag test: only the exact value 1 qualifies (32'd1). Values 2 or 0xFFFFFFFF do not qualify.
- Pivot column is XORed like any other column, so it becomes 0 in every eliminated row.
- The pivot row is never read-for-flag or written.
- ce/we: M_e_ce0=1 only in CHK_RD, PV_RD, TG_RD and WR; M_e_we0=1 only in WR.
- ap_start is ignored outside IDLE. A new accept can occur the cycle after DONE.

Test Plan:
1. pivot_row=-1, rowt=4, colt=4 -> ap_done 2 cycles after accept, elim_count=0, M_e_ce0 never high.
2. rowt=3, colt=4, pivot_row=1, pivot_col=2; rows 0/1/2 = 0011, 1110, 0101 (col0 first) -> row0 becomes 1101, row1 and row2 unchanged, elim_count=1, exactly 4 writes, each write cycle 2 cycles after its pivot read.
3. Same pivot with row2 flag element set to 2 -> row2 untouched, count=1.
4. rowt=4, colt=2, pivot_row=0, rows 1-3 all flagged -> count=3, 6 writes, ap_done at cycle 1+1+3*(3+6)+1 after accept.
5. pivot_row=400, ROW_STRIDE=320 -> pivot base 128000 mod 2^17 = 128000; all pivot reads use addresses 128000+c.
6. Assert ap_rst_n low during a WR cycle -> outputs 0 and IDLE next edge; a new ap_start completes a normal run with a correct count.
